md_ctrl: RTL

- Multiply/divide controller for the E stage. Owns the HI/LO register pair and sequences multi-cycle MULT/DIV operations.
- Produces the HI/LO read value that the pipeline carries forward into the EX/MEM register.
- Raises a stall request to the hazard logic while the unit is busy and decode holds an instruction that touches HI/LO.

---
 rtl/md_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/md_ctrl.sv
// ============================================================================
// md_ctrl : E-stage multiply/divide controller owning the HI/LO pair.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops enabled by macro MD_MADD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        e_mf_sel,
  input  logic        d_md_use,
  output logic [31:0] e_hilo_out,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MTHI  = 4'd5;
  localparam logic [3:0] C_OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] C_OP_MADD  = 4'd7;
  localparam logic [3:0] C_OP_MADDU = 4'd8;
  localparam logic [3:0] C_OP_MSUB  = 4'd9;
  localparam logic [3:0] C_OP_MSUBU = 4'd10;
`endif

  localparam logic [4:0] C_MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] C_DIV_N  = 5'(DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_mac;
  logic        w_start;
  logic        w_commit;

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_sgn;
  logic [31:0]        w_a_abs;
  logic [31:0]        w_b_abs;
  logic [31:0]        w_b_safe;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_q;
  logic [31:0]        w_r;
  logic [63:0]        w_result;

  // Start decode: only an idle unit accepts a new multi-cycle op.
  always_comb begin
    w_is_mul = (e_md_op == C_OP_MULT) || (e_md_op == C_OP_MULTU);
    w_is_div = (e_md_op == C_OP_DIV)  || (e_md_op == C_OP_DIVU);
`ifdef MD_MADD_EN
    w_is_mac = (e_md_op >= C_OP_MADD) && (e_md_op <= C_OP_MSUBU);
`else
    w_is_mac = 1'b0;
`endif
    w_start  = (r_state == S_IDLE) && (w_is_mul || w_is_div || w_is_mac);
    w_commit = (r_state == S_RUN) && (r_cnt == 5'd1);
  end

  // State register plus HI/LO and operand latches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_op  <= e_md_op;
        r_a   <= e_rs;
        r_b   <= e_rt;
        r_cnt <= w_is_div ? C_DIV_N : C_MULT_N;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_commit) begin
        {r_hi, r_lo} <= w_result;
      end else if (r_state == S_IDLE && e_md_op == C_OP_MTHI) begin
        r_hi <= e_rs;
      end else if (r_state == S_IDLE && e_md_op == C_OP_MTLO) begin
        r_lo <= e_rs;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 5'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign-magnitude divide: MIN_INT / -1 falls out naturally as 0x80000000 rem 0.
  always_comb begin
    w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    w_sgn    = (r_op == C_OP_DIV);
    w_a_abs  = (w_sgn && r_a[31]) ? (32'd0 - r_a) : r_a;
    w_b_abs  = (w_sgn && r_b[31]) ? (32'd0 - r_b) : r_b;
    w_b_safe = (w_b_abs == 32'd0) ? 32'd1 : w_b_abs;
    w_q_mag  = w_a_abs / w_b_safe;
    w_r_mag  = w_a_abs % w_b_safe;
    w_q      = (w_sgn && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    w_r      = (w_sgn && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;
    case (r_op)
      C_OP_MULT:  w_result = w_prod_s;
      C_OP_MULTU: w_result = w_prod_u;
      C_OP_DIV, C_OP_DIVU:
        w_result = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF} : {w_r, w_q};
`ifdef MD_MADD_EN
      C_OP_MADD:  w_result = {r_hi, r_lo} + w_prod_s;
      C_OP_MADDU: w_result = {r_hi, r_lo} + w_prod_u;
      C_OP_MSUB:  w_result = {r_hi, r_lo} - w_prod_s;
      C_OP_MSUBU: w_result = {r_hi, r_lo} - w_prod_u;
`endif
      default:    w_result = {r_hi, r_lo};
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (r_state == S_RUN);
    md_stall   = d_md_use && ((r_state == S_RUN) || w_start);
    e_hilo_out = e_mf_sel ? r_lo : r_hi;
    hi         = r_hi;
    lo         = r_lo;
  end

endmodule

`default_nettype wire
